// File: rtl/freq_scan_sched.sv
// Periodic four-channel frequency snapshot with window alarms, streamed one record per handshake.
// Optional FREQ_SCAN_SKIP_UNCHANGED_EN suppresses records identical to the last one sent per channel.
module freq_scan_sched #(
    parameter int unsigned CLK_FREQ    = 20_000_000,
    parameter int unsigned SCAN_PERIOD = CLK_FREQ / 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_en,
    input  logic [79:0] freq_in,
    input  logic [19:0] freq_lo,
    input  logic [19:0] freq_hi,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_ch,
    output logic [19:0] out_freq,
    output logic        out_alarm,
    output logic [3:0]  alarm_flags,
    output logic        scan_done,
    output logic        overrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LATCH,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [23:0] CNT_LAST = 24'(SCAN_PERIOD - 1);

    state_t            state_q, state_d;
    logic [23:0]       cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0][19:0]  snap_q, snap_d;
    logic [3:0]        alarm_q, alarm_d;
    logic              overrun_q, overrun_d;

    logic [3:0][19:0]  freq_arr;
    logic              tick;
    logic [19:0]       cur_freq;
    logic              cur_alarm;
    logic              skip_cur;
    logic              hs;

    assign freq_arr  = freq_in;
    assign tick      = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
    assign cur_freq  = snap_q[idx_q];
    assign cur_alarm = alarm_q[idx_q];
    assign hs        = out_valid && out_ready;

`ifdef FREQ_SCAN_SKIP_UNCHANGED_EN
    logic [3:0][19:0]  last_freq_q, last_freq_d;
    logic [3:0]        last_alarm_q, last_alarm_d;
    logic              send_all_q, send_all_d;

    assign skip_cur = (state_q == ST_SEND) && !send_all_q
                      && (cur_freq == last_freq_q[idx_q])
                      && (cur_alarm == last_alarm_q[idx_q]);

    always_comb begin
        last_freq_d  = last_freq_q;
        last_alarm_d = last_alarm_q;
        send_all_d   = send_all_q;
        if (hs) begin
            last_freq_d[idx_q]  = cur_freq;
            last_alarm_d[idx_q] = cur_alarm;
        end
        // Any pass through IDLE invalidates the history until one full scan has gone out.
        if (state_q == ST_IDLE) begin
            send_all_d = 1'b1;
        end else if (state_q == ST_DONE) begin
            send_all_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_freq_q  <= '0;
            last_alarm_q <= '0;
            send_all_q   <= 1'b0;
        end else begin
            last_freq_q  <= last_freq_d;
            last_alarm_q <= last_alarm_d;
            send_all_q   <= send_all_d;
        end
    end
`else
    assign skip_cur = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        alarm_d   = alarm_q;
        overrun_d = overrun_q;

        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end

        // A tick that lands outside WAIT is dropped and only recorded here.
        if (state_q == ST_IDLE) begin
            overrun_d = 1'b0;
        end else if (tick && (state_q != ST_WAIT)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (scan_en) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!scan_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // The window is folded into the alarm bits here, so it needs no separate copy.
                snap_d = freq_arr;
                for (int unsigned i = 0; i < 4; i++) begin
                    alarm_d[i] = (freq_arr[i] < freq_lo) || (freq_arr[i] > freq_hi);
                end
                idx_d   = 2'd0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (hs || skip_cur) begin
                    if (idx_q == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                if (scan_en) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            alarm_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            alarm_q   <= alarm_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid   = (state_q == ST_SEND) && !skip_cur;
    assign out_ch      = idx_q;
    assign out_freq    = cur_freq;
    assign out_alarm   = cur_alarm;
    assign alarm_flags = alarm_q;
    assign scan_done   = (state_q == ST_DONE);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_freq_scan_sched.sv
// Scoreboard bench for freq_scan_sched: expected records queued by stimulus, popped by a handshake monitor.
module tb_freq_scan_sched;

    localparam int unsigned P = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        scan_en = 1'b0;
    logic [79:0] freq_in = '0;
    logic [19:0] freq_lo = '0;
    logic [19:0] freq_hi = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_ch;
    logic [19:0] out_freq;
    logic        out_alarm;
    logic [3:0]  alarm_flags;
    logic        scan_done;
    logic        overrun;

    freq_scan_sched #(.SCAN_PERIOD(P)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_en     (scan_en),
        .freq_in     (freq_in),
        .freq_lo     (freq_lo),
        .freq_hi     (freq_hi),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ch      (out_ch),
        .out_freq    (out_freq),
        .out_alarm   (out_alarm),
        .alarm_flags (alarm_flags),
        .scan_done   (scan_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  ch;
        logic [19:0] freq;
        logic        alarm;
    } rec_t;

    rec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rec = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic push(input int ch, input int f, input bit a);
        rec_t r;
        r.ch    = ch[1:0];
        r.freq  = f[19:0];
        r.alarm = a;
        sb.push_back(r);
    endtask

    task automatic set_freqs(input int f3, input int f2, input int f1, input int f0);
        freq_in = {f3[19:0], f2[19:0], f1[19:0], f0[19:0]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, output int n);
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            step();
            n++;
            seen = out_valid;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no out_valid in %0d cycles, expected out_valid", name, n);
            n = -1;
        end
    endtask

    task automatic wait_done(input string name, output int n);
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            step();
            n++;
            seen = scan_done;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no scan_done in %0d cycles, expected scan_done", name, n);
            n = -1;
        end
    endtask

    // Handshake monitor: the record presented at the falling edge is accepted on the next rising edge.
    always @(negedge clk) begin
        rec_t e;
        if (rst_n && out_valid && out_ready) begin
            n_rec++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_record: got ch=%0d freq=%0d alarm=%0d, expected no record",
                         out_ch, out_freq, out_alarm);
            end else begin
                e = sb.pop_front();
                check("record", {9'b0, out_ch, out_freq, out_alarm}, {9'b0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int r0;

        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid",   {31'b0, out_valid}, 32'd0);
        check("rst_out_ch",      {30'b0, out_ch}, 32'd0);
        check("rst_out_freq",    {12'b0, out_freq}, 32'd0);
        check("rst_alarm_flags", {28'b0, alarm_flags}, 32'd0);
        check("rst_flags",       {29'b0, scan_done, overrun, out_alarm}, 32'd0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("idle_no_valid", {31'b0, out_valid}, 32'd0);

        set_freqs(40000, 30000, 20000, 10000);
        freq_lo = 20'd15000;
        freq_hi = 20'd35000;

`ifdef FREQ_SCAN_SKIP_UNCHANGED_EN
        push(0, 10000, 1'b1);
        push(1, 20000, 1'b0);
        push(2, 30000, 1'b0);
        push(3, 40000, 1'b1);
        scan_en = 1'b1;
        wait_valid("skip_first", n);
        check("skip_first_latency", n, 32'd18);
        wait_done("skip_done1", n);
        r0 = n_rec;
        wait_done("skip_done2", n);
        check("skip_done_period", n, 32'd16);
        check("skip_scan2_records", n_rec - r0, 32'd0);
        check("skip_alarm_flags", {28'b0, alarm_flags}, 32'b1001);
        set_freqs(40000, 25000, 20000, 10000);
        push(2, 25000, 1'b0);
        r0 = n_rec;
        wait_valid("skip_scan3", n);
        check("skip_scan3_ch", {30'b0, out_ch}, 32'd2);
        wait_done("skip_done3", n);
        check("skip_scan3_records", n_rec - r0, 32'd1);
        scan_en = 1'b0;
        wait_done("skip_done4", n);
        step();
        step();
`else
        for (int s = 0; s < 2; s++) begin
            push(0, 10000, 1'b1);
            push(1, 20000, 1'b0);
            push(2, 30000, 1'b0);
            push(3, 40000, 1'b1);
        end
        scan_en = 1'b1;
        wait_valid("first", n);
        check("first_valid_latency", n, 32'd18);
        check("alarm_flags_window", {28'b0, alarm_flags}, 32'b1001);
        wait_done("done1", n);
        check("done_after_first_valid", n, 32'd4);
        wait_valid("second", n);
        check("scan_period_gap", n, 32'd12);
        wait_done("done2", n);
        check("done2_after_valid", n, 32'd4);
        step();
        check("done_pulse_width", {31'b0, scan_done}, 32'd0);

        // Back-pressure on channel 1.
        push(0, 10000, 1'b1);
        push(1, 20000, 1'b0);
        push(2, 30000, 1'b0);
        push(3, 40000, 1'b1);
        wait_valid("bp", n);
        step();
        check("bp_ch_start", {30'b0, out_ch}, 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_ch",    {30'b0, out_ch}, 32'd1);
            check("bp_freq",  {12'b0, out_freq}, 32'd20000);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_ch", {30'b0, out_ch}, 32'd2);
        wait_done("bp_done", n);
        check("bp_no_overrun", {31'b0, overrun}, 32'd0);

        // Overrun: a long stall lets a tick land in SEND.
        out_ready = 1'b0;
        push(0, 10000, 1'b1);
        push(1, 20000, 1'b0);
        push(2, 30000, 1'b0);
        push(3, 40000, 1'b1);
        wait_valid("ovr", n);
        for (int i = 0; i < 20; i++) step();
        check("ovr_valid_held", {31'b0, out_valid}, 32'd1);
        check("ovr_ch_held", {30'b0, out_ch}, 32'd0);
        check("overrun_set", {31'b0, overrun}, 32'd1);
        scan_en = 1'b0;
        out_ready = 1'b1;
        wait_done("ovr_done", n);
        check("ovr_drain_cycles", n, 32'd4);
        check("overrun_sticky_done", {31'b0, overrun}, 32'd1);
        step();
        step();
        check("overrun_cleared_idle", {31'b0, overrun}, 32'd0);
        for (int i = 0; i < 20; i++) step();
        check("idle_quiet", {31'b0, out_valid}, 32'd0);

        // Reversed window: every channel alarms.
        freq_lo = 20'd50000;
        freq_hi = 20'd100;
        push(0, 10000, 1'b1);
        push(1, 20000, 1'b1);
        push(2, 30000, 1'b1);
        push(3, 40000, 1'b1);
        scan_en = 1'b1;
        wait_valid("rev", n);
        check("rev_latency", n, 32'd18);
        check("rev_alarm_flags", {28'b0, alarm_flags}, 32'hF);
        wait_done("rev_done", n);

        // Reset while channel 2 is on the bus.
        set_freqs(4000, 3000, 2000, 1000);
        freq_lo = 20'd1500;
        freq_hi = 20'd3500;
        push(0, 1000, 1'b1);
        push(1, 2000, 1'b0);
        wait_valid("pre_rst", n);
        step();
        step();
        check("rst_pre_ch", {30'b0, out_ch}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid",   {31'b0, out_valid}, 32'd0);
        check("rst_mid_ch",      {30'b0, out_ch}, 32'd0);
        check("rst_mid_freq",    {12'b0, out_freq}, 32'd0);
        check("rst_mid_alarms",  {28'b0, alarm_flags}, 32'd0);
        check("rst_mid_flags",   {29'b0, scan_done, overrun, out_alarm}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 1000, 1'b1);
        push(1, 2000, 1'b0);
        push(2, 3000, 1'b0);
        push(3, 4000, 1'b1);
        wait_valid("post_rst", n);
        check("post_rst_latency", n, 32'd18);
        check("post_rst_alarm_flags", {28'b0, alarm_flags}, 32'b1001);
        wait_done("post_rst_done", n);
        scan_en = 1'b0;
        step();
        step();
        step();
`endif
        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/freq_scan_sched.md
# freq_scan_sched

Round-robin scan scheduler for the four-channel frequency measurement path. It snapshots all four 20-bit `freq_detector` results on a periodic scan tick and checks each against a common alarm window. It then streams one channel record at a time over a valid/ready interface to the downstream reporting logic. It sits between the four detector instances and the single shared result consumer.

## Interface
- `CLK_FREQ`, 20_000_000, system clock frequency in Hz; informational, used only for the `SCAN_PERIOD` default.
- `SCAN_PERIOD`, CLK_FREQ/10, cycles between scan ticks; legal range 8 to 2^24-1.
- `clk`  in  1  20 MHz system clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `scan_en`  in  1  enables periodic scanning.
- `freq_in`  in  80  packed detector outputs; channel k occupies bits [20k+19:20k], in Hz.
- `freq_lo`  in  20  alarm window lower bound, inclusive.
- `freq_hi`  in  20  alarm window upper bound, inclusive.
- `out_valid`  out  1  record valid.
- `out_ready`  in  1  consumer accepts the record.
- `out_ch`  out  2  channel index of the record.
- `out_freq`  out  20  snapshot frequency of the record.
- `out_alarm`  out  1  record frequency is outside [freq_lo, freq_hi].
- `alarm_flags`  out  4  per-channel alarm bits from the latest snapshot.
- `scan_done`  out  1  one-cycle pulse when a scan completes.
- `overrun`  out  1  sticky flag: a tick arrived while the previous scan was still draining.

## Operation
- Reset values: all outputs 0; FSM in IDLE; period counter 0; snapshot registers 0.
- FSM states: IDLE, WAIT, LATCH, SEND, DONE.
- IDLE: when `scan_en`=1, go to WAIT with the counter cleared.
- WAIT: the counter increments each cycle. At count SCAN_PERIOD-1 the tick fires, the counter wraps to 0, and the FSM goes to LATCH. If `scan_en`=0, return to IDLE immediately.
- LATCH (1 cycle):
  - Capture all 80 bits of `freq_in`, plus `freq_lo` and `freq_hi`.
  - Compute each alarm bit: freq < lo or freq > hi, unsigned compare.
  - Load `alarm_flags` at the end of this cycle.
  - Set the channel index to 0 and go to SEND.
- If `freq_lo` > `freq_hi`, every channel alarms.
- SEND: present channel idx on `out_ch`, `out_freq` and `out_alarm` with `out_valid`=1.
  - Data stays stable until `out_valid` and `out_ready` are both 1 in the same cycle.
  - On that handshake, advance idx; after idx 3, go to DONE.
  - `out_valid` never deasserts without a handshake.
- DONE (1 cycle): pulse `scan_done`. Go to WAIT if `scan_en`=1, else to IDLE.
- The period counter keeps running during LATCH, SEND and DONE. A tick outside WAIT sets `overrun` and is dropped, with no extra scan.
- `overrun` clears only while in IDLE.
- `scan_en` deasserted during LATCH or SEND has no effect until DONE; the in-flight scan always completes.
- Asynchronous reset mid-scan aborts at once: `out_valid`=0, FSM to IDLE, all registers cleared.

## Timing
- Tick to LATCH: the tick is registered in the WAIT cycle where count = SCAN_PERIOD-1, and LATCH is the next cycle.
- First `out_valid`: the cycle after LATCH.
- With `out_ready` held at 1, one record is accepted per cycle. The scan then occupies 6 cycles from LATCH to DONE inclusive.
- `scan_done` is high in the cycle after the channel-3 handshake.
- After `scan_en` rises in IDLE, the first tick fires SCAN_PERIOD+1 cycles later.

## Configuration
- `FREQ_SCAN_SKIP_UNCHANGED_EN` defined:
  - Each channel keeps a copy of its last sent freq and alarm.
  - In SEND, a channel whose snapshot equals its last-sent pair is skipped. A skipped channel occupies one cycle with `out_valid`=0, then idx advances.
  - The first scan after reset, or after leaving IDLE, sends all four channels.
  - `alarm_flags` and `scan_done` behave as without the macro.
- Not defined: all four channels are sent on every scan, and no last-sent storage is synthesized.

## Test plan
- SCAN_PERIOD=16, `scan_en`=1, `out_ready`=1, freq_in = {40000, 30000, 20000, 10000} (ch3..ch0), window [15000, 35000]:
  - Records ch0..ch3 are 10000/1, 20000/0, 30000/0, 40000/1.
  - `alarm_flags`=4'b1001.
  - `scan_done` pulses 5 cycles after LATCH.
  - Scans repeat every 16 cycles.
- Back-pressure: `out_ready` is low for 5 cycles on ch1 -> `out_ch`=1 and `out_freq` stay stable with `out_valid` high, and the handshake completes on the first ready cycle.
- Overrun: `out_ready`=0 for 20 cycles -> `overrun`=1 and only one scan is emitted. `overrun` clears after `scan_en`=0 reaches IDLE.
- Reversed window, `freq_lo`=50000 and `freq_hi`=100 -> all four `out_alarm`=1 and `alarm_flags`=4'hF.
- `rst_n` asserted while in SEND on ch2 -> all outputs 0 that cycle. After release with `scan_en`=1, the first tick occurs SCAN_PERIOD+1 cycles later.
- With `FREQ_SCAN_SKIP_UNCHANGED_EN`: two scans with identical inputs, then ch2 changed to 25000 -> scan 1 emits 4 records, scan 2 emits 0 with `scan_done` still pulsing, and scan 3 emits only ch2.
